// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_e;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_W          = 16;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    // States in which the loader is still consuming the byte stream.
    function automatic logic accepts_bytes(input state_e s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian payload bytes into words and keeps the running XOR checksum.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_done_o,
    output logic [WORD_W-1:0] word_o,
    output logic [BYTE_W-1:0] csum_o
);

    localparam int LOW_W = WORD_W - BYTE_W;
    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [LOW_W-1:0]  low_q;
    logic [BYTE_W-1:0] csum_q;

    // The final byte bypasses the shift register so the word is ready on its handshake.
    assign word_done_o = byte_en_i && (idx_q == LAST_IDX);
    assign word_o      = {byte_i, low_q};
    assign csum_o      = csum_q;
    assign idx_d       = word_done_o ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            idx_q  <= '0;
            low_q  <= '0;
            csum_q <= '0;
        end else if (byte_en_i) begin
            idx_q  <= idx_d;
            low_q  <= {byte_i, low_q[LOW_W-1:BYTE_W]};
            csum_q <= csum_q ^ byte_i;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checked image into instruction memory and
// releases the core only once the whole image has been verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    imem_loader_if.slave        bus,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_wdata,
    output logic                core_run,
    output logic                load_done,
    output logic                load_error,
    output logic [ADDR_W:0]     words_loaded
);

    localparam logic [HDR_W:0] DEPTH = (HDR_W + 1)'(1 << ADDR_W);

    state_e              state_q;
    logic [BYTE_W-1:0]   n_lo_q;
    logic [HDR_W-1:0]    n_q;
    logic [ADDR_W:0]     words_q;
    logic [ADDR_W:0]     words_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                run_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic [HDR_W-1:0]    n_hdr;
    logic                last_word;
    logic                word_done;
    logic [WORD_W-1:0]   word;
    logic [BYTE_W-1:0]   csum;

    // A restart in the same cycle wins over any offered byte.
    assign bus.in_ready = accepts_bytes(state_q) && !restart;
    assign accept       = bus.in_valid && bus.in_ready;
    assign n_hdr        = {bus.in_data, n_lo_q};
    assign words_d      = words_q + 1'b1;
    assign last_word    = (HDR_W'(words_d) == n_q);

    imem_loader_word_assembler u_word_assembler (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (restart),
        .byte_en_i   (accept && (state_q == DATA)),
        .byte_i      (bus.in_data),
        .word_done_o (word_done),
        .word_o      (word),
        .csum_o      (csum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HDR_LO;
            n_lo_q  <= '0;
            n_q     <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (restart) begin
            // Memory contents and the last write address/data are left as they are.
            state_q <= HDR_LO;
            words_q <= '0;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                HDR_LO: begin
                    if (accept) begin
                        n_lo_q  <= bus.in_data;
                        state_q <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        n_q <= n_hdr;
                        if ({1'b0, n_hdr} > DEPTH) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else if (n_hdr == '0) begin
                            state_q <= CSUM;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_done) begin
                        we_q    <= 1'b1;
                        addr_q  <= words_q[ADDR_W-1:0];
                        wdata_q <= DATA_W'(word);
                        words_q <= words_d;
                        if (last_word) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (bus.in_data == csum) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            run_q   <= 1'b1;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                            run_q   <= 1'b0;
                        end
                    end
                end
                DONE, ERROR: begin
                end
                default: begin
                    state_q <= HDR_LO;
                end
            endcase
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_run     = run_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard filled as words are streamed.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              restart = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .bus          (bus),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_run     (core_run),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    int          last_addr = -1;
    bit          gaps = 1'b0;
    logic [39:0] exp_q[$];
    logic [31:0] img_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe is matched against the oldest expected word.
    initial begin : monitor
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                n_writes++;
                last_addr = int'(imem_addr);
                check("write_expected", 64'(exp_q.size() > 0), 64'(1));
                check("write_in_final_state", 64'({load_done, load_error}), 64'(0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_addr_data", 64'({imem_addr, imem_wdata}), 64'(e));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while ((bus.in_ready !== 1'b1) && (guard < 40)) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            check("handshake_timeout", 64'(0), 64'(1));
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
        check("write_latency_we", 64'(imem_we), 64'(1));
        check("write_latency_addr", 64'(imem_addr), 64'(a));
    endtask

    task automatic send_image(input int n, input bit bad_csum);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < img_q.size(); i++) begin
            w  = img_q[i];
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            send_word(w, ADDR_W'(i));
        end
        send_byte(bad_csum ? (cs ^ 8'h01) : cs);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        check({tag, "_we"}, 64'(imem_we), 64'(0));
        check({tag, "_addr"}, 64'(imem_addr), 64'(0));
        check({tag, "_wdata"}, 64'(imem_wdata), 64'(0));
        check({tag, "_core_run"}, 64'(core_run), 64'(0));
        check({tag, "_done"}, 64'(load_done), 64'(0));
        check({tag, "_error"}, 64'(load_error), 64'(0));
        check({tag, "_words"}, 64'(words_loaded), 64'(0));
    endtask

    task automatic do_restart(input string tag);
        restart      = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check({tag, "_ready_during_restart"}, 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        check({tag, "_core_run"}, 64'(core_run), 64'(0));
        check({tag, "_done"}, 64'(load_done), 64'(0));
        check({tag, "_error"}, 64'(load_error), 64'(0));
        check({tag, "_words"}, 64'(words_loaded), 64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word image with the correct checksum.
        img_q = '{32'h0000_0013, 32'h0000_0123};
        send_image(2, 1'b0);
        check("good_done", 64'(load_done), 64'(1));
        check("good_core_run", 64'(core_run), 64'(1));
        check("good_error", 64'(load_error), 64'(0));
        check("good_words", 64'(words_loaded), 64'(2));
        check("good_in_ready", 64'(bus.in_ready), 64'(0));
        check("good_drained", 64'(exp_q.size()), 64'(0));
        do_restart("restart_a");

        // Same image, checksum off by one bit.
        send_image(2, 1'b1);
        check("badcs_error", 64'(load_error), 64'(1));
        check("badcs_core_run", 64'(core_run), 64'(0));
        check("badcs_done", 64'(load_done), 64'(0));
        check("badcs_words", 64'(words_loaded), 64'(2));
        check("badcs_drained", 64'(exp_q.size()), 64'(0));
        do_restart("restart_b");

        // Header larger than memory.
        w0 = n_writes;
        send_byte(8'h01);
        send_byte(8'h01);
        bus.in_valid = 1'b0;
        check("ovf_error", 64'(load_error), 64'(1));
        check("ovf_in_ready", 64'(bus.in_ready), 64'(0));
        check("ovf_core_run", 64'(core_run), 64'(0));
        repeat (3) @(negedge clk);
        check("ovf_no_writes", 64'(n_writes), 64'(w0));
        do_restart("restart_c");

        // Empty image.
        w0 = n_writes;
        img_q.delete();
        send_image(0, 1'b0);
        check("empty_done", 64'(load_done), 64'(1));
        check("empty_core_run", 64'(core_run), 64'(1));
        check("empty_words", 64'(words_loaded), 64'(0));
        check("empty_no_writes", 64'(n_writes), 64'(w0));
        do_restart("restart_d");

        // Reset in the middle of the second word.
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'hCAFE_F00D, ADDR_W'(0));
        send_byte(8'h11);
        send_byte(8'h22);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("midreset");
        check("midreset_drained", 64'(exp_q.size()), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        img_q = '{32'hDDCC_BBAA};
        send_image(1, 1'b0);
        check("fresh_done", 64'(load_done), 64'(1));
        check("fresh_words", 64'(words_loaded), 64'(1));
        check("fresh_last_addr", 64'(last_addr), 64'(0));
        check("fresh_drained", 64'(exp_q.size()), 64'(0));
        do_restart("restart_e");

        // Full-depth image with random valid gaps.
        img_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            img_q.push_back($urandom);
        end
        gaps = 1'b1;
        send_image(DEPTH, 1'b0);
        gaps = 1'b0;
        check("full_done", 64'(load_done), 64'(1));
        check("full_core_run", 64'(core_run), 64'(1));
        check("full_words", 64'(words_loaded), 64'(DEPTH));
        check("full_last_addr", 64'(last_addr), 64'(DEPTH - 1));
        check("full_drained", 64'(exp_q.size()), 64'(0));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
